// File: rtl/code2421_frame_decoder.sv
// code2421_frame_decoder
//
// This is the receive end of the 2421 digit link. It accepts a stream of
// 4-bit 2421-coded digits, most significant digit first, over a valid/ready
// handshake. Each digit is decoded to BCD and checked for legality. NDIGITS
// digits are packed into one BCD word, which is handed downstream over an
// output valid/ready handshake together with a sticky frame error flag.
//
// Parameters:
//   NDIGITS    digits per frame (1..8)
//   BIN_W      width of out_bin; needs 2^BIN_W > 10^NDIGITS - 1
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_code    2421-coded digit
//   in_valid   in_code is valid this cycle
//   in_ready   decoder accepts a digit this cycle
//   flush      synchronous abort of the partial frame (ignored while a word is pending)
//   out_bcd    packed BCD word, MSD in the top nibble
//   out_err    at least one illegal code was seen in the frame
//   out_valid  out_bcd/out_err (and out_bin) are valid
//   out_ready  consumer takes the word
//   out_bin    binary value of the frame (only with CODE2421_BIN_OUT_EN)
//   digit_cnt  digits accepted so far in the current frame
//
// Optional feature: define CODE2421_BIN_OUT_EN to add the out_bin port and
// the bin = bin*10 + digit accumulator behind it.

module code2421_frame_decoder #(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             in_code,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef CODE2421_BIN_OUT_EN
  output logic [BIN_W-1:0]       out_bin,
`endif
  output logic [2:0]             digit_cnt
);

  localparam int W = 4 * NDIGITS;
  // digit_cnt never holds NDIGITS itself: the final accept wraps it to 0.
  localparam logic [2:0] LAST_CNT = 3'(NDIGITS - 1);

  // Reject configurations the counter or the binary output cannot represent.
  if ((NDIGITS < 1) || (NDIGITS > 8) || (BIN_W < 4) || (BIN_W > 32)) begin : g_bad_params
    $error("code2421_frame_decoder: unsupported NDIGITS/BIN_W");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic           err;
  logic           err_next;
  logic [2:0]     cnt;
  logic [3:0]     nib;
  logic           illegal;
  logic           last;

  // 2421 decode: 0..4 map directly, 11..15 map to 5..9 by subtracting 6.
  // Codes 5..10 are illegal and contribute a zero nibble.
  always_comb begin
    nib     = 4'd0;
    illegal = 1'b0;
    if (in_code <= 4'd4) begin
      nib = in_code;
    end else if (in_code >= 4'd11) begin
      nib = in_code - 4'd6;
    end else begin
      illegal = 1'b1;
    end
  end

  // A shift rather than a slice keeps NDIGITS=1 legal.
  assign acc_next  = (acc << 4) | W'(nib);
  assign err_next  = err | illegal;
  assign last      = (cnt == LAST_CNT);
  assign digit_cnt = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Flush beats a simultaneous accept, so it also blocks the move to OUTPUT.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (!flush && in_valid && last) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // The accumulator and flag are cleared as the word is handed to the output
  // registers. Nothing can be accepted in OUTPUT, so they are already clear
  // when the handshake returns the FSM to COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      err     <= 1'b0;
      cnt     <= 3'd0;
      out_bcd <= '0;
      out_err <= 1'b0;
    end else if (state == COLLECT) begin
      if (flush) begin
        acc <= '0;
        err <= 1'b0;
        cnt <= 3'd0;
      end else if (in_valid) begin
        if (last) begin
          out_bcd <= acc_next;
          out_err <= err_next;
          acc     <= '0;
          err     <= 1'b0;
          cnt     <= 3'd0;
        end else begin
          acc <= acc_next;
          err <= err_next;
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

`ifdef CODE2421_BIN_OUT_EN
  logic [BIN_W-1:0] bin_acc;
  logic [BIN_W-1:0] bin_next;

  // Illegal digits already decode to 0, so they add nothing here.
  assign bin_next = bin_acc * BIN_W'(10) + BIN_W'(nib);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_acc <= '0;
      out_bin <= '0;
    end else if (state == COLLECT) begin
      if (flush) begin
        bin_acc <= '0;
      end else if (in_valid) begin
        if (last) begin
          out_bin <= bin_next;
          bin_acc <= '0;
        end else begin
          bin_acc <= bin_next;
        end
      end
    end
  end
`endif

endmodule

// File: doc/code2421_frame_decoder.md
Name: code2421_frame_decoder

Overview:
- Receive end of the 2421 digit link: takes a stream of 4-bit 2421-coded digits, most significant digit first, over a valid/ready handshake.
- Decodes each digit to BCD, checks that it is a legal 2421 code, and assembles NDIGITS digits into one packed BCD word.
- Presents the word with a frame error flag over an output valid/ready handshake to the downstream consumer (display or arithmetic stage).

Parameters:
- NDIGITS, 4, digits per frame (1..8).
- BIN_W, 14, width of the optional binary output; must satisfy 2^BIN_W > 10^NDIGITS - 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_code  input  4  2421-coded digit.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  decoder accepts a digit this cycle.
- flush  input  1  synchronous abort of the partial frame.
- out_bcd  output  4*NDIGITS  packed BCD word; MSD in the top nibble.
- out_err  output  1  at least one illegal code was seen in this frame.
- out_valid  output  1  out_bcd/out_err are valid.
- out_ready  input  1  consumer takes the word.
- digit_cnt  output  3  number of digits accepted in the current frame (status).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to COLLECT.
  - out_bcd=0, out_err=0, out_valid=0, digit_cnt=0, in_ready=1.
  - The accumulator and the error flag are cleared.
- Digit decode:
  - Legal codes: 0000–0100 decode to 0–4; 1011–1111 decode to 5–9 (code − 6, 4-bit arithmetic).
  - Codes 0101–1010 are illegal. An illegal code decodes to nibble 0000 and sets the frame error flag.
  - The error flag is sticky until the frame is delivered or flushed.
- State COLLECT:
  - in_ready=1.
  - A digit is accepted when in_valid && in_ready at a rising edge.
  - On accept: accumulator shifts left 4 bits, decoded nibble enters the low nibble, digit_cnt increments.
  - The accept that brings digit_cnt to NDIGITS moves the state to OUTPUT. The accumulator and flag are copied to out_bcd/out_err, out_valid=1 from the next cycle, and digit_cnt returns to 0.
  - Latency: out_valid rises 1 cycle after the last digit is accepted.
- State OUTPUT:
  - in_ready=0; no digits are accepted.
  - out_bcd/out_err/out_valid hold stable until out_valid && out_ready.
  - On handshake: out_valid=0 next cycle, state returns to COLLECT, and the accumulator and error flag clear.
  - A new frame can start the cycle after the handshake. out_bcd keeps its last value after out_valid drops.
- flush:
  - In COLLECT, flush clears the accumulator, digit_cnt and the error flag next cycle.
  - Flush takes priority over a simultaneous digit accept; that digit is discarded.
  - In OUTPUT, flush is ignored; a completed word is never dropped.
- in_valid while in_ready=0: no effect; the upstream sender must hold the digit.
- Reset mid-frame: the partial frame is lost and the block behaves exactly as out of reset.
- NDIGITS=1: every accepted digit produces a word.

Optional Feature:
- Macro: CODE2421_BIN_OUT_EN.
- Defined:
  - Adds port out_bin, output, BIN_W bits: the binary value of the frame.
  - Built incrementally per accept as bin = bin*10 + decoded digit; illegal digits contribute 0.
  - Registered together with out_bcd and obeys the same valid/hold rules.
  - Reset value 0; cleared on flush and after the output handshake.
- Not defined: no out_bin port and no multiply logic; all other behaviour is identical.

Test Plan:
- Reset, then digits 0001,0010,0011,0100 with in_valid continuous and out_ready=1 -> out_bcd=0x1234, out_err=0, out_valid pulses 1 cycle, one cycle after the 4th accept; out_bin=1234 when the macro is defined.
- Digits 1111,1011,0100,1110 -> out_bcd=0x9548, out_err=0; out_bin=9548 when defined.
- Digits 0001,0111,0011,0000 (0111 illegal) -> out_bcd=0x1030, out_err=1; the next frame 0000,0000,0000,0001 -> out_bcd=0x0001, out_err=0 (flag cleared).
- Complete a frame with out_ready=0 for 5 cycles while in_valid stays high -> out_valid and out_bcd stable, in_ready=0, no digits consumed; raise out_ready -> handshake, then the next digit is accepted in the following cycle.
- Accept 2 digits, then assert flush together with in_valid on digit 1100 -> digit_cnt=0, digit discarded; next frame 0010,0010,0010,0010 -> 0x2222.
- Assert rst_n=0 asynchronously mid-frame (after 3 digits) and between clock edges -> out_valid=0, digit_cnt=0 immediately; release, send 0100,0100,0100,0100 -> 0x4444.
